// File: rtl/tutorial_control_unit.sv
// Instruction sequencer for the tutorial Datapath: accepts one encoded instruction,
// then steps the register strobes and immediates through its T-states.
module tutorial_control_unit #(
  parameter int IMM_W = 8,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [8+IMM_W-1:0] instr,
  output logic               RAout,
  output logic               RBout,
  output logic               RZout,
  output logic               RAin,
  output logic               RBin,
  output logic               RZin,
  output logic [IMM_W-1:0]   AddImmediate,
  output logic [IMM_W-1:0]   RegisterAImmediate,
  output logic               done,
  output logic               illegal,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  localparam int INSTR_W = 8 + IMM_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEC,
    ST_S1,
    ST_S2,
    ST_HLT
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_MV   = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_B = 2'd1;
  localparam logic [1:0] REG_Z = 2'd2;

  typedef struct packed {
    logic             ready;
    logic             a_out;
    logic             b_out;
    logic             z_out;
    logic             a_in;
    logic             b_in;
    logic             z_in;
    logic [IMM_W-1:0] add_imm;
    logic [IMM_W-1:0] reg_a_imm;
    logic             done;
    logic             illegal;
    logic             halted;
  } ctrl_t;

  function automatic logic legal_instr(input logic [INSTR_W-1:0] ir);
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    op = ir[INSTR_W-1 -: 4];
    rd = ir[IMM_W+3 -: 2];
    rs = ir[IMM_W+1 -: 2];
    case (op)
      OP_NOP, OP_HALT: return 1'b1;
      OP_LDI:          return rd == REG_A;
      OP_ADDI:         return (rd == REG_A || rd == REG_B) && (rs == REG_A || rs == REG_B);
      OP_MV:           return (rd == REG_A || rd == REG_B) && (rs != 2'd3) && (rd != rs);
      default:         return 1'b0;
    endcase
  endfunction

  // Moore decode: every control output is a pure function of (state, IR).
  function automatic ctrl_t decode(input state_e st, input logic [INSTR_W-1:0] ir);
    ctrl_t            c;
    logic [3:0]       op;
    logic [1:0]       rd;
    logic [1:0]       rs;
    logic [IMM_W-1:0] imm;
    c   = '0;
    op  = ir[INSTR_W-1 -: 4];
    rd  = ir[IMM_W+3 -: 2];
    rs  = ir[IMM_W+1 -: 2];
    imm = ir[IMM_W-1:0];
    case (st)
      ST_IDLE: c.ready = 1'b1;
      ST_DEC: begin
        if (!legal_instr(ir)) begin
          c.done    = 1'b1;
          c.illegal = 1'b1;
        end else if (op == OP_NOP || op == OP_HALT) begin
          c.done = 1'b1;
        end
      end
      ST_S1: begin
        if (op == OP_LDI) begin
          c.reg_a_imm = imm;
          c.a_in      = 1'b1;
          c.done      = 1'b1;
        end else begin
          c.a_out = (rs == REG_A);
          c.b_out = (rs == REG_B);
          c.z_out = (rs == REG_Z);
          if (op == OP_ADDI) begin
            c.add_imm = imm;
            c.z_in    = 1'b1;
          end else begin
            c.a_in = (rd == REG_A);
            c.b_in = (rd == REG_B);
            c.done = 1'b1;
          end
        end
      end
      ST_S2: begin
        c.z_out = 1'b1;
        c.a_in  = (rd == REG_A);
        c.b_in  = (rd == REG_B);
        c.done  = 1'b1;
      end
      ST_HLT:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [3:0]         ir_op;

  assign ir_op = ir_q[INSTR_W-1 -: 4];

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && ctrl_q.ready) begin
          ir_d    = instr;
          state_d = ST_DEC;
        end
      end
      ST_DEC: begin
        if (!legal_instr(ir_q) || ir_op == OP_NOP) state_d = ST_IDLE;
        else if (ir_op == OP_HALT)                 state_d = ST_HLT;
        else                                       state_d = ST_S1;
      end
      ST_S1:   state_d = (ir_op == OP_ADDI) ? ST_S2 : ST_IDLE;
      ST_S2:   state_d = ST_IDLE;
      ST_HLT:  state_d = ST_HLT;
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    ctrl_d = decode(state_d, ir_d);
    if (ctrl_q.done && !ctrl_q.illegal) retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      ctrl_q    <= decode(ST_IDLE, '0);
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ctrl_q    <= ctrl_d;
      retired_q <= retired_d;
    end
  end

  assign instr_ready        = ctrl_q.ready;
  assign RAout              = ctrl_q.a_out;
  assign RBout              = ctrl_q.b_out;
  assign RZout              = ctrl_q.z_out;
  assign RAin               = ctrl_q.a_in;
  assign RBin               = ctrl_q.b_in;
  assign RZin               = ctrl_q.z_in;
  assign AddImmediate       = ctrl_q.add_imm;
  assign RegisterAImmediate = ctrl_q.reg_a_imm;
  assign done               = ctrl_q.done;
  assign illegal            = ctrl_q.illegal;
  assign halted             = ctrl_q.halted;
  assign retired            = retired_q;

endmodule

// File: tb/tb_tutorial_control_unit.sv
// Self-checking bench for tutorial_control_unit: directed vector table, hand-written
// clear/halt/wrap sequences, and random instructions against a per-cycle schedule model.
module tb_tutorial_control_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic        instr_valid;
  logic [15:0] instr;

  logic        instr_ready, RAout, RBout, RZout, RAin, RBin, RZin, done, illegal, halted;
  logic [7:0]  AddImmediate, RegisterAImmediate;
  logic [15:0] retired;

  // Second instance with a 4-bit counter so wrap-around is reachable quickly.
  logic        w_ready, w_raout, w_rbout, w_rzout, w_rain, w_rbin, w_rzin, w_done, w_illegal, w_halted;
  logic [7:0]  w_add_imm, w_rega_imm;
  logic [3:0]  w_retired;

  tutorial_control_unit #(.IMM_W(8), .CNT_W(16)) dut (
    .clock(clock), .clear(clear), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .RAout(RAout), .RBout(RBout), .RZout(RZout), .RAin(RAin), .RBin(RBin),
    .RZin(RZin), .AddImmediate(AddImmediate), .RegisterAImmediate(RegisterAImmediate),
    .done(done), .illegal(illegal), .halted(halted), .retired(retired)
  );

  tutorial_control_unit #(.IMM_W(8), .CNT_W(4)) dut_w (
    .clock(clock), .clear(clear), .instr_valid(instr_valid), .instr_ready(w_ready),
    .instr(instr), .RAout(w_raout), .RBout(w_rbout), .RZout(w_rzout), .RAin(w_rain),
    .RBin(w_rbin), .RZin(w_rzin), .AddImmediate(w_add_imm),
    .RegisterAImmediate(w_rega_imm), .done(w_done), .illegal(w_illegal),
    .halted(w_halted), .retired(w_retired)
  );

  always #5 clock = ~clock;

  // strb bit order: {RAout, RBout, RZout, RAin, RBin, RZin}
  typedef struct packed {
    logic       ready;
    logic [5:0] strb;
    logic [7:0] add_imm;
    logic [7:0] rega_imm;
    logic       done;
    logic       illegal;
    logic       halted;
  } exp_t;

  localparam logic [5:0] S_RAOUT = 6'b100000;
  localparam logic [5:0] S_RBOUT = 6'b010000;
  localparam logic [5:0] S_RZOUT = 6'b001000;
  localparam logic [5:0] S_RAIN  = 6'b000100;
  localparam logic [5:0] S_RBIN  = 6'b000010;
  localparam logic [5:0] S_RZIN  = 6'b000001;

  typedef struct {
    string       name;
    logic [15:0] ins;
    int          n;
    exp_t        c0, c1, c2;
    bit          retire;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_ret;
  exp_t        exp_q[$];
  vec_t        vecs[$];

  function automatic exp_t mk(input logic [5:0] s, input logic [7:0] ai, input logic [7:0] ri,
                              input logic d, input logic il);
    exp_t e;
    e = '0;
    e.strb = s; e.add_imm = ai; e.rega_imm = ri; e.done = d; e.illegal = il;
    return e;
  endfunction

  function automatic exp_t exp_idle();
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic exp_t exp_hlt();
    exp_t e;
    e = '0;
    e.halted = 1'b1;
    return e;
  endfunction

  function automatic exp_t act_main();
    exp_t a;
    a = {instr_ready, RAout, RBout, RZout, RAin, RBin, RZin, AddImmediate, RegisterAImmediate,
         done, illegal, halted};
    return a;
  endfunction

  function automatic exp_t act_w();
    exp_t a;
    a = {w_ready, w_raout, w_rbout, w_rzout, w_rain, w_rbin, w_rzin, w_add_imm, w_rega_imm,
         w_done, w_illegal, w_halted};
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input exp_t e);
    check(name, 32'(act_main()), 32'(e));
    check({name, "_w"}, 32'(act_w()), 32'(e));
  endtask

  task automatic check_ret(input string name);
    check({name, "_retired"}, 32'(retired), 32'(model_ret));
    check({name, "_retired_w"}, 32'(w_retired), 32'(model_ret[3:0]));
  endtask

  function automatic logic [5:0] out_bit(input logic [1:0] r);
    return (r == 2'd0) ? S_RAOUT : (r == 2'd1) ? S_RBOUT : S_RZOUT;
  endfunction

  function automatic logic [5:0] in_bit(input logic [1:0] r);
    return (r == 2'd0) ? S_RAIN : (r == 2'd1) ? S_RBIN : S_RZIN;
  endfunction

  // Reference schedule: one expected output record per cycle, starting with the decode cycle.
  function automatic void model(input logic [15:0] ins, output bit legal);
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm;
    op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
    exp_q.delete();
    case (op)
      4'h0, 4'hF: legal = 1'b1;
      4'h1:       legal = (rd == 2'd0);
      4'h2:       legal = (rd <= 2'd1) && (rs <= 2'd1);
      4'h3:       legal = (rd <= 2'd1) && (rs <= 2'd2) && (rd != rs);
      default:    legal = 1'b0;
    endcase
    if (!legal || op == 4'h0 || op == 4'hF) begin
      exp_q.push_back(mk(6'd0, 8'd0, 8'd0, 1'b1, !legal));
      return;
    end
    exp_q.push_back(mk(6'd0, 8'd0, 8'd0, 1'b0, 1'b0));
    case (op)
      4'h1: exp_q.push_back(mk(S_RAIN, 8'd0, imm, 1'b1, 1'b0));
      4'h2: begin
        exp_q.push_back(mk(out_bit(rs) | S_RZIN, imm, 8'd0, 1'b0, 1'b0));
        exp_q.push_back(mk(S_RZOUT | in_bit(rd), 8'd0, 8'd0, 1'b1, 1'b0));
      end
      default: exp_q.push_back(mk(out_bit(rs) | in_bit(rd), 8'd0, 8'd0, 1'b1, 1'b0));
    endcase
  endfunction

  // Entered just after a negedge with the DUT idle; leaves just after the negedge of the ready cycle.
  task automatic run_seq(input string name, input logic [15:0] ins, input bit junk, input bit legal);
    instr_valid = 1'b1;
    instr       = ins;
    foreach (exp_q[i]) begin
      @(negedge clock);
      instr_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      instr       = 16'($urandom);
      check_outs($sformatf("%s_c%0d", name, i), exp_q[i]);
    end
    @(negedge clock);
    instr_valid = 1'b0;
    if (legal) model_ret++;
    check_outs({name, "_after"}, (ins[15:12] == 4'hF) ? exp_hlt() : exp_idle());
    check_ret(name);
  endtask

  task automatic do_clear(input string name);
    @(negedge clock);
    clear       = 1'b1;
    instr_valid = 1'b1;
    instr       = 16'h1005;
    @(negedge clock);
    clear       = 1'b0;
    instr_valid = 1'b0;
    model_ret   = '0;
    check_outs({name, "_reset"}, exp_idle());
    check_ret(name);
    @(negedge clock);
    check_outs({name, "_no_accept"}, exp_idle());
  endtask

  task automatic add_vec(input string name, input logic [15:0] ins, input int n, input exp_t c0,
                         input exp_t c1, input exp_t c2, input bit retire);
    vec_t v;
    v.name = name; v.ins = ins; v.n = n; v.c0 = c0; v.c1 = c1; v.c2 = c2; v.retire = retire;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t z0, ill;
    bit   legal;
    z0  = mk(6'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    ill = mk(6'd0, 8'd0, 8'd0, 1'b1, 1'b1);

    add_vec("ldi_a_5",       16'h1005, 2, z0, mk(S_RAIN, 8'd0, 8'd5, 1'b1, 1'b0), z0, 1'b1);
    add_vec("addi_b_a_5",    16'h2405, 3, z0, mk(S_RAOUT | S_RZIN, 8'd5, 8'd0, 1'b0, 1'b0),
            mk(S_RZOUT | S_RBIN, 8'd0, 8'd0, 1'b1, 1'b0), 1'b1);
    add_vec("mv_a_z",        16'h3200, 2, z0, mk(S_RZOUT | S_RAIN, 8'd0, 8'd0, 1'b1, 1'b0), z0, 1'b1);
    add_vec("op7_illegal",   16'h7000, 1, ill, z0, z0, 1'b0);
    add_vec("ldi_b_illegal", 16'h1400, 1, ill, z0, z0, 1'b0);
    add_vec("nop",           16'h0000, 1, mk(6'd0, 8'd0, 8'd0, 1'b1, 1'b0), z0, z0, 1'b1);
    add_vec("addi_a_b_ff",   16'h21FF, 3, z0, mk(S_RBOUT | S_RZIN, 8'hFF, 8'd0, 1'b0, 1'b0),
            mk(S_RZOUT | S_RAIN, 8'd0, 8'd0, 1'b1, 1'b0), 1'b1);
    add_vec("mv_b_a",        16'h3400, 2, z0, mk(S_RAOUT | S_RBIN, 8'd0, 8'd0, 1'b1, 1'b0), z0, 1'b1);
    add_vec("mv_b_b_ill",    16'h3500, 1, ill, z0, z0, 1'b0);
    add_vec("addi_rs_z_ill", 16'h2207, 1, ill, z0, z0, 1'b0);
    add_vec("mv_rd_z_ill",   16'h3800, 1, ill, z0, z0, 1'b0);
    add_vec("ldi_a_ff",      16'h10FF, 2, z0, mk(S_RAIN, 8'd0, 8'hFF, 1'b1, 1'b0), z0, 1'b1);

    clear       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    model_ret   = '0;
    do_clear("init");

    foreach (vecs[k]) begin
      exp_q.delete();
      exp_q.push_back(vecs[k].c0);
      if (vecs[k].n > 1) exp_q.push_back(vecs[k].c1);
      if (vecs[k].n > 2) exp_q.push_back(vecs[k].c2);
      run_seq(vecs[k].name, vecs[k].ins, 1'b0, vecs[k].retire);
    end

    // HALT is sticky: valid instructions are ignored until clear.
    model(16'hF000, legal);
    run_seq("halt", 16'hF000, 1'b0, legal);
    for (int i = 0; i < 4; i++) begin
      instr_valid = 1'b1;
      instr       = 16'h1005;
      @(negedge clock);
      check_outs($sformatf("halted_hold%0d", i), exp_hlt());
      check_ret($sformatf("halted_hold%0d", i));
    end
    do_clear("after_halt");

    // Clear in ADDI S1 aborts: S2 is never entered.
    instr_valid = 1'b1;
    instr       = 16'h2405;
    @(negedge clock);
    instr_valid = 1'b0;
    check_outs("abort_dec", z0);
    @(negedge clock);
    check_outs("abort_s1", mk(S_RAOUT | S_RZIN, 8'd5, 8'd0, 1'b0, 1'b0));
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    model_ret = '0;
    check_outs("abort_cleared", exp_idle());
    check_ret("abort_cleared");
    @(negedge clock);
    check_outs("abort_no_s2", exp_idle());

    // Counter wrap on the 4-bit instance: 16 legal NOPs bring it back to 0.
    for (int i = 0; i < 16; i++) begin
      model(16'h0000, legal);
      run_seq($sformatf("wrap_nop%0d", i), 16'h0000, 1'b0, legal);
    end
    check("wrap_w_zero", 32'(w_retired), 32'd0);

    // Random instructions with junk valid pulses while busy.
    for (int i = 0; i < 200; i++) begin
      logic [3:0]  op;
      logic [15:0] ins;
      int          r;
      r = $urandom_range(0, 9);
      case (r)
        0:          op = 4'h0;
        1, 2:       op = 4'h1;
        3, 4, 5:    op = 4'h2;
        6, 7:       op = 4'h3;
        default:    op = 4'($urandom_range(4, 14));
      endcase
      ins = {op, 12'($urandom)};
      model(ins, legal);
      run_seq($sformatf("rand%0d_%h", i, ins), ins, 1'b1, legal);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
